mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Memory-mapped I/O bridge on the processor data-memory port, between the processor's `wren`/`address_dmem`/`data`/`q_dmem` and the data RAM. Word addresses 4096–8191 are decoded to game peripherals; all other addresses pass through to RAM. The peripherals are an LED register, a button-press event FIFO and a free-running tick timer. Game software polls buttons, drives LEDs and measures time with plain `lw`/`sw`.

## Interface

Parameters:
- FIFO_DEPTH, 8: button event FIFO entries; must be a power of 2, minimum 2.
- PRESCALE, 50000: clock cycles per timer tick; minimum 1.
- DEBOUNCE_CYCLES, 65536: consecutive stable cycles required before a debounced button state changes. Only used with MMIO_DEBOUNCE_EN.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- address_dmem  in  32  word address from the processor.
- data  in  32  store data from the processor.
- wren  in  1  store strobe from the processor.
- q_dmem  out  32  load data returned to the processor.
- ram_wren  out  1  RAM write enable, equal to `wren & !io_sel`. RAM addr/dataIn are wired directly from the processor.
- ram_q  in  32  RAM dataOut.
- buttons  in  4  raw, asynchronous button inputs, active-high.
- leds  out  4  LED drive, registered.

## Operation

- Decode: `io_sel = (address_dmem[31:12] == 20'h00001)`.
- Register map (word addresses):
  - 4096 LED: write loads `data[3:0]` into `leds`. Read returns the zero-extended LED value.
  - 4097 BTN_HEAD: read returns `{valid, 29'b0, code[1:0]}`, where `code` is the button index at the FIFO head. Reads 0 when the FIFO is empty. Reads are non-destructive. Any write pops the head; a pop on an empty FIFO is a no-op.
  - 4098 STATUS: read returns `{23'b0, overflow, 4'b0, count[3:0]}`. Any write clears `overflow`.
  - 4099 TIMER: read returns the 32-bit tick count. Write loads `data` and clears the prescaler.
  - 4100–8191: read 0; writes ignored.
- Button events:
  - Each button passes through a 2-flop synchronizer, then the optional debouncer, then a rising-edge detect.
  - At most one push per cycle. When several edges occur in the same cycle, the lowest index is pushed and the rest are dropped with `overflow` set.
- FIFO boundary cases:
  - Push while full with no pop: event dropped, `overflow` set to 1 (sticky).
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - Push and pop in the same cycle while empty: pop is a no-op, push stored, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
  - STATUS `count` saturates its field at 15 for depths above 15.
- Timer:
  - The prescaler counts 0 to PRESCALE-1. On wrap, the tick count increments modulo 2^32.
  - A TIMER write in the same cycle as a tick: the write wins.

## Timing

- Reads have one-cycle latency, matching the synchronous RAM. `io_sel` and the I/O read value are registered at the rising edge. `q_dmem = sel_q ? io_q : ram_q`, combinational from those registers.
- A read of a register being written in the same cycle returns the pre-write value.
- Writes take effect at the rising edge where `wren` is high. `leds` and status change after that edge.
- Press latency without debounce: the event is in the FIFO after the third rising edge following `buttons[i]` going high.
- Press latency with debounce: 3 + DEBOUNCE_CYCLES edges.
- Reset (`reset == 0` at an edge) sets: `leds = 0`, FIFO empty, `overflow = 0`, timer 0, prescaler 0, synchronizers and debouncers 0, `sel_q = 1`, `io_q = 0`. As a result `q_dmem = 0` after the reset edge.
- Reset mid-operation discards pending events and any in-flight read.

## Configuration

- `MMIO_DEBOUNCE_EN` defined: the debounce counter is instantiated. A change in the synchronized input must persist DEBOUNCE_CYCLES consecutive cycles before the debounced state flips. The counter restarts on any glitch.
- `MMIO_DEBOUNCE_EN` undefined: the edge detect operates directly on the synchronizer output, and DEBOUNCE_CYCLES is ignored.

## Structure

- Package `mmio_pkg` holds:
  - the IO base (4096) and register offsets (LED=0, BTN_HEAD=1, STATUS=2, TIMER=3);
  - the BTN code width (2);
  - the STATUS bit positions (count [3:0], overflow [8]).
- Sub-module `btn_conditioner`: one button's synchronizer, debouncer and edge pulse. It is instantiated 4 times. The FIFO, timer and decode stay in mmio_bridge.

## Test plan

- Store 32'hA to 4096, then load 4096 → `leds` = 4'hA from the next edge; `q_dmem` = 10 one cycle after the load. Store/load to address 20 reaches RAM: `ram_wren` high and data returned.
- Press `buttons[2]` (debounce off) → 3 edges later, BTN_HEAD reads 32'h8000_0002 and STATUS reads count = 1. Write 4097 → BTN_HEAD reads 0 and count = 0.
- Nine distinct presses with FIFO_DEPTH = 8 → count = 8, STATUS bit 8 = 1, the ninth event is lost. Write 4098 → `overflow` = 0.
- FIFO full, then a press and a write to 4097 in the same cycle → count stays 8, `overflow` stays 0, head advances.
- PRESCALE = 4: 12 cycles after reset, TIMER reads 3. Write 100 to 4099 on a tick cycle → reads 100, then 101 after 4 more cycles.
- With MMIO_DEBOUNCE_EN and DEBOUNCE_CYCLES = 8: a 5-cycle pulse → no event; a 12-cycle pulse → exactly one event.
- Any of the above: pull `reset` low mid-sequence → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the processor MMIO bridge: IO page, register offsets and STATUS layout.
// Combinational helpers only, so no latency and no backpressure.
package mmio_pkg;

    localparam int IO_BASE = 4096;
    localparam logic [19:0] IO_PAGE = 20'(IO_BASE >> 12);

    localparam logic [11:0] OFF_LED      = 12'd0;
    localparam logic [11:0] OFF_BTN_HEAD = 12'd1;
    localparam logic [11:0] OFF_STATUS   = 12'd2;
    localparam logic [11:0] OFF_TIMER    = 12'd3;

    localparam int BTN_CODE_W = 2;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 4;
    localparam int STAT_OVF_BIT   = 8;

    typedef enum logic [2:0] {
        REG_LED,
        REG_BTN_HEAD,
        REG_STATUS,
        REG_TIMER,
        REG_NONE
    } io_reg_e;

    function automatic io_reg_e decode_off(input logic [11:0] off);
        case (off)
            OFF_LED:      return REG_LED;
            OFF_BTN_HEAD: return REG_BTN_HEAD;
            OFF_STATUS:   return REG_STATUS;
            OFF_TIMER:    return REG_TIMER;
            default:      return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One button: 2-flop synchronizer, optional debouncer (MMIO_DEBOUNCE_EN), rising-edge pulse.
// Pulse is asserted 2 edges after the raw rise (2 + DEBOUNCE_CYCLES with debounce); no backpressure.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic pulse
);
    logic sync1, sync2, stable, stable_d;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;
    logic            db_state;

    // Any return to the current debounced level restarts the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            db_cnt   <= '0;
            db_state <= 1'b0;
        end else if (sync2 != db_state) begin
            if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                db_state <= sync2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end else begin
            db_cnt <= '0;
        end
    end

    assign stable = db_state;
`else
    logic db_unused;
    assign db_unused = (DEBOUNCE_CYCLES < 1);
    assign stable    = sync2;
`endif

    assign pulse = stable & ~stable_d;

endmodule

// File: rtl/mmio_bridge.sv
// Data-memory MMIO bridge: LED register, button event FIFO and tick timer at words 4096-8191, rest to RAM.
// Reads return one cycle later like the RAM; no backpressure (MMIO_DEBOUNCE_EN adds button debounce).
module mmio_bridge #(
    parameter int FIFO_DEPTH      = 8,
    parameter int PRESCALE        = 50000,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        ram_wren,
    input  logic [31:0] ram_q,
    input  logic [3:0]  buttons,
    output logic [3:0]  leds
);
    import mmio_pkg::*;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic    io_sel;
    io_reg_e io_reg;
    logic    wr_led, wr_btn, wr_status, wr_timer;

    assign io_sel    = (address_dmem[31:12] == IO_PAGE);
    assign io_reg    = decode_off(address_dmem[11:0]);
    assign ram_wren  = wren & ~io_sel;
    assign wr_led    = wren & io_sel & (io_reg == REG_LED);
    assign wr_btn    = wren & io_sel & (io_reg == REG_BTN_HEAD);
    assign wr_status = wren & io_sel & (io_reg == REG_STATUS);
    assign wr_timer  = wren & io_sel & (io_reg == REG_TIMER);

    logic [3:0] pulse;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_conditioner #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clock(clock),
            .reset(reset),
            .raw  (buttons[i]),
            .pulse(pulse[i])
        );
    end

    logic                  push_req, multi_edge;
    logic [BTN_CODE_W-1:0] push_code;

    always_comb begin
        push_code = '0;
        for (int i = 3; i >= 0; i--) begin
            if (pulse[i]) push_code = BTN_CODE_W'(i);
        end
    end

    assign push_req   = |pulse;
    assign multi_edge = (pulse & (pulse - 4'd1)) != 4'd0;

    logic [BTN_CODE_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  empty, full, pop, push, drop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign pop   = wr_btn & ~empty;
    // A pop frees the slot the same cycle, so a full FIFO still accepts.
    assign push  = push_req & (~full | pop);
    assign drop  = push_req & full & ~pop;

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= push_code;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop | multi_edge) overflow <= 1'b1;
            else if (wr_status)    overflow <= 1'b0;
        end
    end

    logic [PSC_W-1:0] presc;
    logic [31:0]      timer;
    logic             tick;

    assign tick = (presc == PSC_W'(PRESCALE - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            presc <= '0;
            timer <= '0;
        end else if (wr_timer) begin
            presc <= '0;
            timer <= data;
        end else if (tick) begin
            presc <= '0;
            timer <= timer + 32'd1;
        end else begin
            presc <= presc + PSC_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)      leds <= 4'd0;
        else if (wr_led) leds <= data[3:0];
    end

    logic [31:0] cnt_ext, status_word, rd_val;

    assign cnt_ext = 32'(count);

    always_comb begin
        status_word = '0;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
        status_word[STAT_OVF_BIT] = overflow;
    end

    always_comb begin
        rd_val = '0;
        case (io_reg)
            REG_LED:      rd_val = {28'd0, leds};
            REG_BTN_HEAD: begin
                if (!empty) begin
                    rd_val[31]             = 1'b1;
                    rd_val[BTN_CODE_W-1:0] = fifo_mem[rd_ptr];
                end
            end
            REG_STATUS:   rd_val = status_word;
            REG_TIMER:    rd_val = timer;
            default:      rd_val = '0;
        endcase
    end

    logic        sel_q;
    logic [31:0] io_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sel_q <= 1'b1;
            io_q  <= '0;
        end else begin
            sel_q <= io_sel;
            io_q  <= rd_val;
        end
    end

    assign q_dmem = sel_q ? io_q : ram_q;

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a 64-word RAM model; FIFO_DEPTH=8, PRESCALE=4, DEBOUNCE_CYCLES=8.
module tb_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = 32'd63;
    logic [31:0] data = 32'd0;
    logic        wren = 1'b0;
    logic [31:0] q_dmem;
    logic        ram_wren;
    logic [31:0] ram_q = 32'd0;
    logic [3:0]  buttons = 4'd0;
    logic [3:0]  leds;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    mmio_bridge #(
        .FIFO_DEPTH     (8),
        .PRESCALE       (4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .address_dmem(address_dmem),
        .data        (data),
        .wren        (wren),
        .q_dmem      (q_dmem),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .buttons     (buttons),
        .leds        (leds)
    );

    logic [31:0] ram [0:63] = '{default: 32'd0};

    always @(posedge clock) begin
        if (ram_wren) ram[address_dmem[5:0]] <= data;
        ram_q <= ram[address_dmem[5:0]];
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_ramwr;
        logic [31:0] exp_q;
        logic [3:0]  exp_leds;
    } vec_t;

    vec_t vt [18];

    function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic rw, input logic [31:0] q, input logic [3:0] l);
        vec_t v;
        v.wr = w; v.addr = a; v.wdata = d; v.exp_ramwr = rw; v.exp_q = q; v.exp_leds = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wren = 1'b0;
        address_dmem = 32'd63;
        data = 32'd0;
    endtask

    task automatic acc(input logic w, input logic [31:0] a, input logic [31:0] d);
        wren = w;
        address_dmem = a;
        data = d;
        cyc();
        idle();
    endtask

    task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
        acc(1'b0, a, 32'd0);
        chk(nm, q_dmem, exp);
    endtask

    task automatic wrq(input string nm, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_prev);
        acc(1'b1, a, d);
        chk(nm, q_dmem, exp_prev);
    endtask

    task automatic press(input int b);
        buttons = 4'(1 << b);
        repeat (3) cyc();
        buttons = 4'd0;
        repeat (3) cyc();
    endtask

    initial begin
        vt[0]  = mk(0, 32'd4096, 32'd0,          0, 32'd0,          4'h0);
        vt[1]  = mk(1, 32'd4096, 32'hA,          0, 32'd0,          4'hA);
        vt[2]  = mk(0, 32'd4096, 32'd0,          0, 32'd10,         4'hA);
        vt[3]  = mk(1, 32'd20,   32'h1234_5678,  1, 32'd0,          4'hA);
        vt[4]  = mk(0, 32'd20,   32'd0,          0, 32'h1234_5678,  4'hA);
        vt[5]  = mk(0, 32'd4100, 32'd0,          0, 32'd0,          4'hA);
        vt[6]  = mk(1, 32'd4100, 32'd5,          0, 32'd0,          4'hA);
        vt[7]  = mk(0, 32'd8191, 32'd0,          0, 32'd0,          4'hA);
        vt[8]  = mk(1, 32'd4096, 32'hFFFF_FFF3,  0, 32'd10,         4'h3);
        vt[9]  = mk(0, 32'd4096, 32'd0,          0, 32'd3,          4'h3);
        vt[10] = mk(1, 32'd8192, 32'd77,         1, 32'd0,          4'h3);
        vt[11] = mk(0, 32'd0,    32'd0,          0, 32'd77,         4'h3);
        vt[12] = mk(0, 32'd4095, 32'd0,          0, 32'd0,          4'h3);
        vt[13] = mk(0, 32'd4097, 32'd0,          0, 32'd0,          4'h3);
        vt[14] = mk(1, 32'd4097, 32'd0,          0, 32'd0,          4'h3);
        vt[15] = mk(0, 32'd4098, 32'd0,          0, 32'd0,          4'h3);
        vt[16] = mk(1, 32'd4098, 32'd0,          0, 32'd0,          4'h3);
        vt[17] = mk(0, 32'd4098, 32'd0,          0, 32'd0,          4'h3);

        // Reset edge, then the timer sequence counted from it.
        cyc();
        chk("rst0_q", q_dmem, 32'd0);
        chk("rst0_leds", 32'(leds), 32'd0);
        reset = 1'b1;
        repeat (12) cyc();
        rd("tmr_12cyc", 32'd4099, 32'd3);
        repeat (2) cyc();
        wrq("tmr_wr_on_tick", 32'd4099, 32'd100, 32'd3);
        rd("tmr_after_wr", 32'd4099, 32'd100);
        repeat (2) cyc();
        rd("tmr_pre_tick", 32'd4099, 32'd100);
        rd("tmr_tick", 32'd4099, 32'd101);

        for (int i = 0; i < 18; i++) begin
            wren = vt[i].wr;
            address_dmem = vt[i].addr;
            data = vt[i].wdata;
            #1;
            chk($sformatf("v%0d_ramwr", i), 32'(ram_wren), 32'(vt[i].exp_ramwr));
            cyc();
            idle();
            chk($sformatf("v%0d_q", i), q_dmem, vt[i].exp_q);
            chk($sformatf("v%0d_leds", i), 32'(leds), 32'(vt[i].exp_leds));
        end

`ifdef MMIO_DEBOUNCE_EN
        buttons = 4'b0001;
        repeat (5) cyc();
        buttons = 4'd0;
        repeat (20) cyc();
        rd("db_short_cnt", 32'd4098, 32'd0);
        buttons = 4'b0001;
        repeat (12) cyc();
        buttons = 4'd0;
        repeat (30) cyc();
        rd("db_long_cnt", 32'd4098, 32'd1);
        rd("db_long_head", 32'd4097, 32'h8000_0000);
`else
        buttons = 4'b0100;
        repeat (2) cyc();
        rd("btn_early", 32'd4097, 32'd0);
        rd("btn_head", 32'd4097, 32'h8000_0002);
        rd("btn_cnt1", 32'd4098, 32'd1);
        wrq("btn_pop_prev", 32'd4097, 32'd0, 32'h8000_0002);
        rd("btn_head_empty", 32'd4097, 32'd0);
        rd("btn_cnt0", 32'd4098, 32'd0);
        buttons = 4'd0;
        repeat (3) cyc();

        for (int i = 0; i < 9; i++) press(i % 4);
        rd("full_status", 32'd4098, 32'h0000_0108);
        rd("full_head", 32'd4097, 32'h8000_0000);
        acc(1'b1, 32'd4098, 32'd0);
        rd("ovf_cleared", 32'd4098, 32'd8);

        buttons = 4'b1000;
        repeat (2) cyc();
        wrq("full_pushpop_prev", 32'd4097, 32'd0, 32'h8000_0000);
        rd("full_pushpop_cnt", 32'd4098, 32'd8);
        rd("full_pushpop_head", 32'd4097, 32'h8000_0001);
        buttons = 4'd0;
        repeat (3) cyc();

        // Drain to a known state with a single entry left.
        for (int i = 0; i < 7; i++) acc(1'b1, 32'd4097, 32'd0);
        rd("drain_cnt", 32'd4098, 32'd1);
        rd("drain_tail", 32'd4097, 32'h8000_0003);
        acc(1'b1, 32'd4097, 32'd0);

        buttons = 4'b1010;
        repeat (3) cyc();
        buttons = 4'd0;
        rd("multi_head", 32'd4097, 32'h8000_0001);
        rd("multi_status", 32'd4098, 32'h0000_0101);
        acc(1'b1, 32'd4098, 32'd0);
        acc(1'b1, 32'd4097, 32'd0);
        rd("empty_again", 32'd4098, 32'd0);

        buttons = 4'b0100;
        repeat (2) cyc();
        wrq("empty_pushpop_prev", 32'd4097, 32'd0, 32'd0);
        rd("empty_pushpop_cnt", 32'd4098, 32'd1);
        rd("empty_pushpop_head", 32'd4097, 32'h8000_0002);
        buttons = 4'd0;
        repeat (3) cyc();
`endif

        // Reset during a pending STATUS read that would otherwise return 1.
        reset = 1'b0;
        wren = 1'b0;
        address_dmem = 32'd4098;
        cyc();
        chk("rst_mid_q", q_dmem, 32'd0);
        chk("rst_mid_leds", 32'(leds), 32'd0);
        reset = 1'b1;
        idle();
        rd("rst_status", 32'd4098, 32'd0);
        rd("rst_head", 32'd4097, 32'd0);
        rd("rst_led", 32'd4096, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
